// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of the byte-enabled data memory: the core has fixed
// priority, the DMA port gets a forced grant after MAX_WAIT denials and may run locked bursts.
module dmem_arbiter #(
  parameter int MAX_WAIT = 4,
  parameter int MAX_LOCK = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        c_req,
  input  logic [3:0]  c_we,
  input  logic [31:0] c_addr,
  input  logic [31:0] c_wdata,
  output logic        c_gnt,
  output logic        c_stall,
  output logic        c_rvalid,
  output logic [31:0] c_rdata,
  input  logic        d_req,
  input  logic [3:0]  d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic        d_lock,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  output logic [3:0]  mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  localparam int WW = $clog2(MAX_WAIT + 1);
  localparam int LW = $clog2(MAX_LOCK + 1);
  localparam logic [WW-1:0] WAIT_LIMIT = WW'(MAX_WAIT);
  localparam logic [LW-1:0] LOCK_LIMIT = LW'(MAX_LOCK);

  typedef enum logic {ARB = 1'b0, LOCK = 1'b1} state_t;

  state_t        state_q, state_d;
  logic [WW-1:0] wait_q, wait_d;
  logic [LW-1:0] lock_q, lock_d;
  logic          c_rvalid_q, d_rvalid_q;
  logic [31:0]   c_rdata_q, d_rdata_q;
  logic          c_gnt_s, d_gnt_s, lock_hold_s, c_rd_s, d_rd_s;

  // Grant selection, state/counter next values and memory mux.
  always_comb begin
    c_gnt_s     = 1'b0;
    d_gnt_s     = 1'b0;
    state_d     = state_q;
    wait_d      = wait_q;
    lock_d      = lock_q;
    lock_hold_s = (state_q == LOCK) && d_req && d_lock;

    if (rst) begin
      c_gnt_s = 1'b0;
      d_gnt_s = 1'b0;
    end else if (lock_hold_s) begin
      // One core-priority cycle once the burst has used its budget.
      if ((lock_q == LOCK_LIMIT) && c_req) begin
        c_gnt_s = 1'b1;
      end else begin
        d_gnt_s = 1'b1;
      end
    end else if (c_req && d_req) begin
      if (wait_q == WAIT_LIMIT) begin
        d_gnt_s = 1'b1;
      end else begin
        c_gnt_s = 1'b1;
      end
    end else begin
      c_gnt_s = c_req;
      d_gnt_s = d_req;
    end

    if (d_gnt_s && d_lock) begin
      state_d = LOCK;
      if (state_q == LOCK) begin
        lock_d = (lock_q == LOCK_LIMIT) ? lock_q : lock_q + LW'(1);
      end else begin
        lock_d = LW'(1);
      end
    end else begin
      state_d = ARB;
      lock_d  = '0;
    end

    if (d_gnt_s || !d_req) begin
      wait_d = '0;
    end else if (wait_q != WAIT_LIMIT) begin
      wait_d = wait_q + WW'(1);
    end else begin
      wait_d = wait_q;
    end

    c_rd_s = c_gnt_s && (c_we == 4'b0000);
    d_rd_s = d_gnt_s && (d_we == 4'b0000);

    if (d_gnt_s) begin
      mem_addr  = d_addr;
      mem_wdata = d_wdata;
      mem_we    = d_we;
    end else if (c_gnt_s) begin
      mem_addr  = c_addr;
      mem_wdata = c_wdata;
      mem_we    = c_we;
    end else begin
      mem_addr  = c_addr;
      mem_wdata = c_wdata;
      mem_we    = 4'b0000;
    end
  end

  // State, counters and one-cycle-latency read response registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ARB;
      wait_q     <= '0;
      lock_q     <= '0;
      c_rvalid_q <= 1'b0;
      d_rvalid_q <= 1'b0;
      c_rdata_q  <= 32'h0000_0000;
      d_rdata_q  <= 32'h0000_0000;
    end else begin
      state_q    <= state_d;
      wait_q     <= wait_d;
      lock_q     <= lock_d;
      c_rvalid_q <= c_rd_s;
      d_rvalid_q <= d_rd_s;
      if (c_rd_s) begin
        c_rdata_q <= mem_rdata;
      end
      if (d_rd_s) begin
        d_rdata_q <= mem_rdata;
      end
    end
  end

  assign c_gnt   = c_gnt_s;
  assign d_gnt   = d_gnt_s;
  assign c_stall = c_req & ~c_gnt_s;
  // A response due in a reset cycle is suppressed immediately.
  assign c_rvalid = c_rvalid_q & ~rst;
  assign d_rvalid = d_rvalid_q & ~rst;
  assign c_rdata  = c_rdata_q;
  assign d_rdata  = d_rdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: table-driven arbitration vectors plus
// hand-written read/write, locked-burst and reset sequences against a small memory model.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        c_req, d_req, d_lock;
  logic [3:0]  c_we, d_we;
  logic [31:0] c_addr, c_wdata, d_addr, d_wdata;
  logic        c_gnt, c_stall, c_rvalid, d_gnt, d_rvalid;
  logic [31:0] c_rdata, d_rdata;
  logic [3:0]  mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  logic        pl_en;
  logic [5:0]  pl_idx;
  logic [31:0] pl_val;
  logic [31:0] mem [0:63];

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic c_req;
    logic d_req;
    logic e_c;
    logic e_d;
  } vec_t;

  localparam int NV = 26;
  vec_t tbl [0:NV-1];

  always #5 clk = ~clk;

  dmem_arbiter #(.MAX_WAIT(4), .MAX_LOCK(8)) dut (
    .clk(clk), .rst(rst),
    .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
    .c_gnt(c_gnt), .c_stall(c_stall), .c_rvalid(c_rvalid), .c_rdata(c_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_lock(d_lock), .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  assign mem_rdata = mem[mem_addr[7:2]];

  always @(posedge clk) begin
    if (pl_en) begin
      mem[pl_idx] <= pl_val;
    end else begin
      for (int b = 0; b < 4; b++) begin
        if (mem_we[b]) mem[mem_addr[7:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
      end
    end
  end

  task automatic chk1(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%b required=%b", nm, act, exp);
    end
  endtask

  task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(input logic cr, input logic dr, input logic ec, input logic ed);
    vec_t v;
    v.c_req = cr;
    v.d_req = dr;
    v.e_c   = ec;
    v.e_d   = ed;
    return v;
  endfunction

  initial begin
    // Contention: core 4 cycles, DMA forced on the 5th, repeating.
    for (int i = 0; i < 15; i++) begin
      tbl[i] = mk(1'b1, 1'b1, (i % 5) != 4, (i % 5) == 4);
    end
    // Wait clear: 3 denials, DMA idle one cycle, then 4 more denials before the grant.
    for (int i = 15; i < 18; i++) tbl[i] = mk(1'b1, 1'b1, 1'b1, 1'b0);
    tbl[18] = mk(1'b1, 1'b0, 1'b1, 1'b0);
    for (int i = 19; i < 23; i++) tbl[i] = mk(1'b1, 1'b1, 1'b1, 1'b0);
    tbl[23] = mk(1'b1, 1'b1, 1'b0, 1'b1);
    tbl[24] = mk(1'b0, 1'b1, 1'b0, 1'b1);
    tbl[25] = mk(1'b0, 1'b0, 1'b0, 1'b0);

    rst = 1'b1; c_req = 1'b1; d_req = 1'b1; d_lock = 1'b0;
    c_we = 4'b1111; d_we = 4'b1111;
    c_addr = 32'h0000_0010; d_addr = 32'h0000_0020;
    c_wdata = 32'h0000_0000; d_wdata = 32'h0000_0000;
    pl_en = 1'b1; pl_idx = 6'd4; pl_val = 32'hDEAD_BEEF;
    tick();
    pl_idx = 6'd8; pl_val = 32'h1122_3344;
    tick();
    pl_en = 1'b0;
    #1;
    chk1("rst_c_gnt", c_gnt, 1'b0);
    chk1("rst_d_gnt", d_gnt, 1'b0);
    chk32("rst_mem_we", {28'h0, mem_we}, 32'h0);
    chk1("rst_c_rvalid", c_rvalid, 1'b0);
    chk1("rst_d_rvalid", d_rvalid, 1'b0);
    chk32("rst_c_rdata", c_rdata, 32'h0);
    chk32("rst_d_rdata", d_rdata, 32'h0);

    // Core read.
    tick();
    rst = 1'b0; c_req = 1'b1; c_we = 4'b0000; d_req = 1'b0; d_we = 4'b0000;
    #1;
    chk1("crd_gnt", c_gnt, 1'b1);
    chk1("crd_stall", c_stall, 1'b0);
    chk32("crd_addr", mem_addr, 32'h0000_0010);
    tick();
    c_req = 1'b0;
    #1;
    chk1("crd_rvalid", c_rvalid, 1'b1);
    chk32("crd_rdata", c_rdata, 32'hDEAD_BEEF);
    tick();
    chk1("crd_rvalid_once", c_rvalid, 1'b0);
    chk32("crd_rdata_hold", c_rdata, 32'hDEAD_BEEF);

    // Table vectors.
    for (int i = 0; i < NV; i++) begin
      c_req = tbl[i].c_req;
      d_req = tbl[i].d_req;
      #1;
      chk1($sformatf("v%0d_c_gnt", i), c_gnt, tbl[i].e_c);
      chk1($sformatf("v%0d_d_gnt", i), d_gnt, tbl[i].e_d);
      chk1($sformatf("v%0d_c_stall", i), c_stall, tbl[i].c_req & ~tbl[i].e_c);
      chk32($sformatf("v%0d_addr", i), mem_addr, tbl[i].e_d ? 32'h0000_0020 : 32'h0000_0010);
      chk32($sformatf("v%0d_we", i), {28'h0, mem_we}, 32'h0);
      tick();
    end

    // DMA byte write, then read back.
    c_req = 1'b0; d_req = 1'b1; d_we = 4'b0100; d_wdata = 32'h00AB_0000;
    #1;
    chk1("dwr_gnt", d_gnt, 1'b1);
    chk32("dwr_we", {28'h0, mem_we}, 32'h0000_0004);
    tick();
    d_we = 4'b0000;
    #1;
    chk1("dwr_no_rvalid", d_rvalid, 1'b0);
    chk32("dwr_mem", mem[8], 32'h11AB_3344);
    tick();
    d_req = 1'b0;
    #1;
    chk1("drd_rvalid", d_rvalid, 1'b1);
    chk32("drd_rdata", d_rdata, 32'h11AB_3344);
    chk32("c_rdata_hold", c_rdata, 32'hDEAD_BEEF);
    tick();

    // Locked burst: 4 core, 8 DMA, 1 core-priority cycle.
    c_req = 1'b1; d_req = 1'b1; d_lock = 1'b1;
    for (int i = 0; i < 13; i++) begin
      #1;
      chk1($sformatf("lk%0d_d_gnt", i), d_gnt, (i >= 4) && (i <= 11));
      chk1($sformatf("lk%0d_c_gnt", i), c_gnt, (i < 4) || (i == 12));
      tick();
    end
    d_lock = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk1($sformatf("post%0d_c_gnt", i), c_gnt, 1'b1);
      tick();
    end
    c_req = 1'b0;
    #1;
    chk1("post_d_only", d_gnt, 1'b1);
    tick();
    d_req = 1'b0;

    // Reset mid-operation.
    c_req = 1'b1; c_we = 4'b0000; c_addr = 32'h0000_0010;
    #1;
    chk1("mr_gnt", c_gnt, 1'b1);
    tick();
    rst = 1'b1; c_we = 4'b1111; c_wdata = 32'hFFFF_FFFF;
    #1;
    chk1("mr_rvalid", c_rvalid, 1'b0);
    chk1("mr_c_gnt", c_gnt, 1'b0);
    chk32("mr_mem_we", {28'h0, mem_we}, 32'h0);
    tick();
    chk32("mr_c_rdata", c_rdata, 32'h0);
    rst = 1'b0; c_req = 1'b0;
    tick();
    chk32("mr_mem_kept", mem[4], 32'hDEAD_BEEF);
    chk1("mr_rvalid_after", c_rvalid, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
